dvp_capture: RTL and testbench

//   Front-end capture stage that sits directly upstream of format_converter.

---
 rtl/dvp_capture_if.sv | 24 ++
 rtl/dvp_capture.sv | 237 +++++++++++++++++++++++
 tb/tb_dvp_capture.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dvp_capture_if.sv
// DVP capture bus: raw camera-side signals in, packed pixel stream out.
// The slave modport is the capture block's view. The master modport is the view
// of whatever drives the camera pins and consumes the pixels.
interface dvp_capture_if;
    logic        vsync;
    logic        href;
    logic [7:0]  din;
    logic [15:0] pix_data;
    logic        pix_vld;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        sof;
    logic        eof;

    modport master (
        output vsync, href, din,
        input  pix_data, pix_vld, pix_x, pix_y, sof, eof
    );

    modport slave (
        input  vsync, href, din,
        output pix_data, pix_vld, pix_x, pix_y, sof, eof
    );
endinterface

// File: rtl/dvp_capture.sv
// dvp_capture: samples DVP vsync/href/din in the system clock domain.
// After init_done it discards warm-up frames. It then packs byte pairs into
// RGB565 pixels that carry x/y coordinates and sof/eof markers.
// Optional feature macro: DVP_FRAME_CHECK_EN adds per-frame geometry checking
// and the sticky frame_err output.
module dvp_capture #(
    parameter int H_ACT       = 640,
    parameter int V_ACT       = 480,
    parameter int SKIP_FRAMES = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            init_done,
    dvp_capture_if.slave    bus,
    output logic            capturing,
    output logic [7:0]      frame_cnt
`ifdef DVP_FRAME_CHECK_EN
    ,
    output logic            frame_err
`endif
);

    localparam logic [9:0] X_MAX     = 10'(H_ACT);
    localparam logic [9:0] X_LAST    = 10'(H_ACT - 1);
    localparam logic [8:0] Y_MAX     = 9'(V_ACT);
    localparam logic [8:0] Y_LAST    = 9'(V_ACT - 1);
    localparam logic [7:0] SKIP_LAST = 8'(SKIP_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, SKIP, ACTIVE} state_t;

    state_t      state;
    logic [7:0]  skip_cnt;
    logic        phase;
    logic        line_pair;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [7:0]  hi;

    logic        vs_p0, hr_p0, vs_prev, hr_prev;
    logic [7:0]  d_p0;
    logic        vs_rise, hr_fall;

    logic        vld_p1, sof_p1, eof_p1;
    logic [15:0] data_p1;
    logic [9:0]  x_p1;
    logic [8:0]  y_p1;

    // Column counter saturates at H_ACT so overlong lines stop emitting.
    function automatic logic [9:0] sat_inc_x(input logic [9:0] v);
        return (v >= X_MAX) ? X_MAX : v + 10'd1;
    endfunction

    // Row counter saturates at V_ACT so extra lines stop emitting.
    function automatic logic [8:0] sat_inc_y(input logic [8:0] v);
        return (v >= Y_MAX) ? Y_MAX : v + 9'd1;
    endfunction

    assign vs_rise = vs_p0 & ~vs_prev;
    assign hr_fall = ~hr_p0 & hr_prev;

    // Stage p0: register raw DVP pins once, keep previous levels for edge detect.
    always_ff @(posedge clk) begin
        d_p0 <= bus.din;
        if (rst) begin
            vs_p0   <= 1'b0;
            hr_p0   <= 1'b0;
            vs_prev <= 1'b0;
            hr_prev <= 1'b0;
        end else begin
            vs_p0   <= bus.vsync;
            hr_p0   <= bus.href;
            vs_prev <= vs_p0;
            hr_prev <= hr_p0;
        end
    end

    // Stage p1 control: capture FSM, byte phase, x/y counters, pixel qualifiers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            skip_cnt  <= 8'd0;
            phase     <= 1'b0;
            line_pair <= 1'b0;
            x         <= 10'd0;
            y         <= 9'd0;
            vld_p1    <= 1'b0;
            sof_p1    <= 1'b0;
            eof_p1    <= 1'b0;
            capturing <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            sof_p1 <= 1'b0;
            eof_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    skip_cnt <= 8'd0;
                    if (init_done)
                        state <= SKIP;
                end
                SKIP: begin
                    if (vs_rise) begin
                        if (skip_cnt == SKIP_LAST) begin
                            // The frame that starts on this edge is captured.
                            state     <= ACTIVE;
                            capturing <= 1'b1;
                            x         <= 10'd0;
                            y         <= 9'd0;
                            phase     <= 1'b0;
                            line_pair <= 1'b0;
                        end else begin
                            skip_cnt <= skip_cnt + 8'd1;
                        end
                    end
                end
                ACTIVE: begin
                    if (vs_rise) begin
                        // New frame wins over a coincident byte, which is dropped.
                        x         <= 10'd0;
                        y         <= 9'd0;
                        phase     <= 1'b0;
                        line_pair <= 1'b0;
                    end else if (hr_p0) begin
                        phase <= ~phase;
                        if (phase) begin
                            line_pair <= 1'b1;
                            x         <= sat_inc_x(x);
                            if (x < X_MAX && y < Y_MAX) begin
                                vld_p1 <= 1'b1;
                                sof_p1 <= (x == 10'd0) && (y == 9'd0);
                                eof_p1 <= (x == X_LAST) && (y == Y_LAST);
                            end
                        end
                    end else if (hr_fall) begin
                        // Line end: a pending odd byte is discarded with the phase.
                        phase     <= 1'b0;
                        x         <= 10'd0;
                        line_pair <= 1'b0;
                        if (line_pair)
                            y <= sat_inc_y(y);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage p1 data: high-byte holding register and assembled pixel word.
    always_ff @(posedge clk) begin
        if (state == ACTIVE && !vs_rise && hr_p0) begin
            if (!phase) begin
                hi <= d_p0;
            end else begin
                data_p1 <= {hi, d_p0};
                x_p1    <= x;
                y_p1    <= y;
            end
        end
    end

    // Stage p2: registered pixel outputs and completed-frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.pix_vld  <= 1'b0;
            bus.sof      <= 1'b0;
            bus.eof      <= 1'b0;
            bus.pix_data <= 16'd0;
            bus.pix_x    <= 10'd0;
            bus.pix_y    <= 9'd0;
            frame_cnt    <= 8'd0;
        end else begin
            bus.pix_vld <= vld_p1;
            bus.sof     <= sof_p1;
            bus.eof     <= eof_p1;
            if (vld_p1) begin
                bus.pix_data <= data_p1;
                bus.pix_x    <= x_p1;
                bus.pix_y    <= y_p1;
            end
            if (bus.eof)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

`ifdef DVP_FRAME_CHECK_EN
    localparam logic [10:0] P_EXP = 11'(H_ACT);
    localparam logic [10:0] P_MAX = 11'(H_ACT + 1);
    localparam logic [9:0]  L_EXP = 10'(V_ACT);
    localparam logic [9:0]  L_MAX = 10'(V_ACT + 1);

    logic [10:0] chk_pairs;
    logic [9:0]  chk_lines;
    logic        chk_bad;
    logic        chk_armed;

    // Pair count saturates one above H_ACT so an overlong line still mismatches.
    function automatic logic [10:0] sat_inc_p(input logic [10:0] v);
        return (v >= P_MAX) ? P_MAX : v + 11'd1;
    endfunction

    // Line count saturates one above V_ACT for the same reason.
    function automatic logic [9:0] sat_inc_l(input logic [9:0] v);
        return (v >= L_MAX) ? L_MAX : v + 10'd1;
    endfunction

    // Frame geometry check; the first frame boundary after entering ACTIVE only arms it.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            chk_armed <= 1'b0;
            chk_pairs <= 11'd0;
            chk_lines <= 10'd0;
            chk_bad   <= 1'b0;
        end else if (state != ACTIVE) begin
            chk_armed <= 1'b0;
            chk_pairs <= 11'd0;
            chk_lines <= 10'd0;
            chk_bad   <= 1'b0;
        end else if (vs_rise) begin
            if (chk_armed && (chk_bad || chk_lines != L_EXP))
                frame_err <= 1'b1;
            chk_armed <= 1'b1;
            chk_pairs <= 11'd0;
            chk_lines <= 10'd0;
            chk_bad   <= 1'b0;
        end else if (hr_p0) begin
            if (phase)
                chk_pairs <= sat_inc_p(chk_pairs);
        end else if (hr_fall) begin
            chk_lines <= sat_inc_l(chk_lines);
            chk_pairs <= 11'd0;
            if (chk_pairs != P_EXP || phase)
                chk_bad <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dvp_capture.sv
// Directed bench for dvp_capture with H_ACT=4, V_ACT=2, SKIP_FRAMES=2.
module tb_dvp_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_done;
    logic       capturing;
    logic [7:0] frame_cnt;
`ifdef DVP_FRAME_CHECK_EN
    logic       frame_err;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    dvp_capture_if bus ();

    dvp_capture #(.H_ACT(4), .V_ACT(2), .SKIP_FRAMES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .init_done (init_done),
        .bus       (bus.slave),
        .capturing (capturing),
        .frame_cnt (frame_cnt)
`ifdef DVP_FRAME_CHECK_EN
        ,
        .frame_err (frame_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] d;
        logic [9:0]  x;
        logic [8:0]  y;
        logic        sof;
        logic        eof;
        int          cyc;
    } pix_t;

    pix_t cap_q[$];

    // Pixel capture away from the active edge.
    always @(negedge clk) begin
        if (bus.pix_vld)
            cap_q.push_back('{bus.pix_data, bus.pix_x, bus.pix_y, bus.sof, bus.eof, cyc});
    end

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] d;
        logic [9:0]  x;
        logic [8:0]  y;
        logic        sof;
        logic        eof;
    } pvec_t;

    typedef struct {
        int         nbytes;
        logic [7:0] base;
        int         exp_pix;
        logic [8:0] exp_y;
    } lvec_t;

    pvec_t t3[8];
    lvec_t lt[3];

    function automatic logic [63:0] pk(input logic [15:0] d, input logic [9:0] x,
                                       input logic [8:0] y, input logic s, input logic e);
        return {27'd0, d, x, y, s, e};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vsync_pulse();
        bus.vsync = 1'b1;
        repeat (2) tick();
        bus.vsync = 1'b0;
        repeat (2) tick();
    endtask

    // Drives one href line of n bytes base, base+1, ...; k2 is the edge that samples byte 1.
    task automatic send_line(input int n, input logic [7:0] base, output int k2);
        k2 = 0;
        bus.href = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.din = base + 8'(i);
            if (i == 1) k2 = cyc + 1;
            tick();
        end
        bus.href = 1'b0;
        bus.din  = 8'h00;
        repeat (3) tick();
    endtask

    task automatic good_frame();
        int k;
        vsync_pulse();
        send_line(8, 8'h01, k);
        send_line(8, 8'h01, k);
    endtask

    initial begin
        int k2;
        int nmin;
        logic [7:0] b0;

        t3[0] = '{8'h01, 8'h02, 16'h0102, 10'd0, 9'd0, 1'b1, 1'b0};
        t3[1] = '{8'h03, 8'h04, 16'h0304, 10'd1, 9'd0, 1'b0, 1'b0};
        t3[2] = '{8'h05, 8'h06, 16'h0506, 10'd2, 9'd0, 1'b0, 1'b0};
        t3[3] = '{8'h07, 8'h08, 16'h0708, 10'd3, 9'd0, 1'b0, 1'b0};
        t3[4] = '{8'h01, 8'h02, 16'h0102, 10'd0, 9'd1, 1'b0, 1'b0};
        t3[5] = '{8'h03, 8'h04, 16'h0304, 10'd1, 9'd1, 1'b0, 1'b0};
        t3[6] = '{8'h05, 8'h06, 16'h0506, 10'd2, 9'd1, 1'b0, 1'b0};
        t3[7] = '{8'h07, 8'h08, 16'h0708, 10'd3, 9'd1, 1'b0, 1'b1};

        lt[0] = '{12, 8'h20, 4, 9'd0};
        lt[1] = '{7,  8'h40, 3, 9'd1};
        lt[2] = '{8,  8'h60, 0, 9'd2};

        rst = 1'b1; init_done = 1'b0;
        bus.vsync = 1'b0; bus.href = 1'b0; bus.din = 8'h00;

        // Reset with toggling pins
        for (int i = 0; i < 5; i++) begin
            bus.vsync = i[0];
            bus.href  = i[1];
            bus.din   = 8'($urandom);
            tick();
        end
        check("rst_pix_vld",   bus.pix_vld, 0);
        check("rst_pix_data",  bus.pix_data, 0);
        check("rst_pix_xy",    {bus.pix_x, bus.pix_y}, 0);
        check("rst_sof_eof",   {bus.sof, bus.eof}, 0);
        check("rst_capturing", capturing, 0);
        check("rst_frame_cnt", frame_cnt, 0);
`ifdef DVP_FRAME_CHECK_EN
        check("rst_frame_err", frame_err, 0);
`endif
        rst = 1'b0;
        bus.vsync = 1'b0; bus.href = 1'b0; bus.din = 8'h00;
        repeat (3) tick();
        check("rst_no_pix", cap_q.size(), 0);

        // Idle ignores vsync without init_done
        vsync_pulse();
        check("idle_capturing", capturing, 0);

        // Skip two warm-up frames
        init_done = 1'b1; tick(); init_done = 1'b0;
        vsync_pulse();
        check("skip1_capturing", capturing, 0);
        send_line(8, 8'h01, k2);
        check("skip_no_pix", cap_q.size(), 0);
        vsync_pulse();
        check("skip2_capturing", capturing, 1);
        check("skip2_no_pix", cap_q.size(), 0);

        // Packing frame driven from the pixel table
        for (int l = 0; l < 2; l++) begin
            bus.href = 1'b1;
            for (int j = 0; j < 4; j++) begin
                bus.din = t3[l*4+j].hi; tick();
                bus.din = t3[l*4+j].lo; tick();
            end
            bus.href = 1'b0; bus.din = 8'h00;
            repeat (3) tick();
        end
        check("pack_count", cap_q.size(), 8);
        nmin = (cap_q.size() < 8) ? cap_q.size() : 8;
        for (int i = 0; i < nmin; i++)
            check($sformatf("pack_pix%0d", i),
                  pk(cap_q[i].d, cap_q[i].x, cap_q[i].y, cap_q[i].sof, cap_q[i].eof),
                  pk(t3[i].d, t3[i].x, t3[i].y, t3[i].sof, t3[i].eof));
        check("pack_frame_cnt", frame_cnt, 1);

        // Second good frame (first frame boundary in ACTIVE)
        cap_q.delete();
        good_frame();
        check("f2_count", cap_q.size(), 8);
        check("f2_frame_cnt", frame_cnt, 2);

        // Overlong, odd and extra lines, with latency on the first pair
        vsync_pulse();
`ifdef DVP_FRAME_CHECK_EN
        check("chk_good_err", frame_err, 0);
`endif
        for (int l = 0; l < 3; l++) begin
            cap_q.delete();
            send_line(lt[l].nbytes, lt[l].base, k2);
            check($sformatf("line%0d_count", l), cap_q.size(), lt[l].exp_pix);
            nmin = (cap_q.size() < lt[l].exp_pix) ? cap_q.size() : lt[l].exp_pix;
            for (int j = 0; j < nmin; j++) begin
                b0 = lt[l].base + 8'(2*j);
                check($sformatf("line%0d_pix%0d", l, j),
                      pk(cap_q[j].d, cap_q[j].x, cap_q[j].y, cap_q[j].sof, cap_q[j].eof),
                      pk({b0, b0 + 8'd1}, 10'(j), lt[l].exp_y,
                         (j == 0) && (lt[l].exp_y == 9'd0), 1'b0));
            end
            if (l == 0 && cap_q.size() > 0)
                check("latency", cap_q[0].cyc, k2 + 2);
        end
        check("bad_frame_cnt", frame_cnt, 2);

        // frame_cnt wrap over 254 more complete frames
        for (int f = 0; f < 254; f++) begin
            cap_q.delete();
            good_frame();
`ifdef DVP_FRAME_CHECK_EN
            if (f == 0) check("chk_bad_err", frame_err, 1);
`endif
            if (f == 252) check("cnt_255", frame_cnt, 255);
        end
        check("cnt_wrap", frame_cnt, 0);
`ifdef DVP_FRAME_CHECK_EN
        check("chk_sticky_err", frame_err, 1);
`endif

        // Reset in the middle of a frame
        vsync_pulse();
        send_line(4, 8'hA1, k2);
        check("mid_pix_data", {bus.pix_data, bus.pix_x}, {16'hA3A4, 10'd1});
        check("mid_capturing", capturing, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mrst_pix_data", bus.pix_data, 0);
        check("mrst_pix_x", bus.pix_x, 0);
        check("mrst_capturing", capturing, 0);
`ifdef DVP_FRAME_CHECK_EN
        check("mrst_frame_err", frame_err, 0);
`endif
        cap_q.delete();
        repeat (3) vsync_pulse();
        send_line(8, 8'h01, k2);
        check("mrst_no_recapture", cap_q.size(), 0);
        check("mrst_still_idle", capturing, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
